// File: rtl/nexys4_7seg_scan_if.sv
// Purpose : display-data load port and scanned 7-seg drive bundle for nexys4_7seg_scan.
// Latency : n/a (signal bundle only).
// Backpr. : none; load is a fire-and-forget strobe, last load before a frame boundary wins.
// Signals : load/value/dots/digit_en (master -> scanner), upd_pending/frame_tick/hex/dot/an (scanner -> master).
interface nexys4_7seg_scan_if;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dots;
  logic [7:0]  digit_en;
  logic        upd_pending;
  logic        frame_tick;
  logic [3:0]  hex;
  logic        dot;
  logic [7:0]  an;

  // Master supplies display data and observes the scanner.
  modport master (
    output load, value, dots, digit_en,
    input  upd_pending, frame_tick, hex, dot, an
  );

  // The scanner itself.
  modport slave (
    input  load, value, dots, digit_en,
    output upd_pending, frame_tick, hex, dot, an
  );
endinterface

// File: rtl/nexys4_7seg_scan.sv
// Purpose : time-multiplexed scanner for eight common-anode 7-seg digits, with a double
//           buffer (pending/shadow) swapped only at frame boundaries and a blanking gap per digit.
// Latency : registered outputs, change on the edge that enters a state/digit; loads land at the next frame boundary.
// Backpr. : none; loads are never refused, a newer load overwrites pending data.
// Ports   : clk, rst_n (async active-low); bus (slave modport): load/value/dots/digit_en in,
//           upd_pending/frame_tick/hex/dot/an out.
// Option  : define LEADING_ZERO_BLANK_EN to darken leading all-zero, dot-less digits (digit 0 always shown).
module nexys4_7seg_scan #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  nexys4_7seg_scan_if.slave  bus
);

  localparam int CMAX1 = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CMAX  = (CMAX1 > 2) ? CMAX1 : 2;
  localparam int CW    = $clog2(CMAX);
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dots;
    logic [7:0]  en;
  } disp_t;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  disp_t         pend_q, pend_d;
  disp_t         shadow_q, shadow_d;
  logic          upd_q, upd_d;
  logic          tick_q, tick_d;
  logic [3:0]    hex_q, hex_d;
  logic          dot_q, dot_d;
  logic [7:0]    an_q, an_d;
  logic          boundary;
  logic [7:0]    supp;

  // State register plus all output/buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BLANK;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      pend_q   <= '0;
      shadow_q <= '0;
      upd_q    <= 1'b0;
      tick_q   <= 1'b0;
      hex_q    <= 4'h0;
      dot_q    <= 1'b1;
      an_q     <= 8'hFF;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      upd_q    <= upd_d;
      tick_q   <= tick_d;
      hex_q    <= hex_d;
      dot_q    <= dot_d;
      an_q     <= an_d;
    end
  end

  // Next-state: scan sequencing and the pending -> shadow transfer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (BLANK_CYCLES == 0 || cnt_q == BLK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == DIG_LAST) begin
          // Without blanking, SHOW chains straight into the next digit.
          state_d  = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
          idx_d    = idx_q + 3'd1;
          cnt_d    = '0;
          boundary = (idx_q == 3'd7);
        end
      end
    endcase

    // Transfer consumes the old pending data; a coincident load refills pending.
    tick_d   = boundary && upd_q;
    shadow_d = tick_d ? pend_q : shadow_q;
    pend_d   = pend_q;
    upd_d    = upd_q;
    if (bus.load) begin
      pend_d = '{value: bus.value, dots: bus.dots, en: bus.digit_en};
      upd_d  = 1'b1;
    end else if (tick_d) begin
      upd_d  = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is suppressed when digits 7..i are all zero nibbles without dots.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp     = '0;
    for (int i = 7; i >= 0; i--) begin
      zero_run = zero_run && (shadow_d.value[i*4 +: 4] == 4'h0) && !shadow_d.dots[i];
      supp[i]  = zero_run && (i != 0);
    end
  end
`else
  assign supp = '0;
`endif

  // Output decode from the state being entered, so outputs are valid on entry.
  always_comb begin
    hex_d = shadow_d.value[{idx_d, 2'b00} +: 4];
    dot_d = ~shadow_d.dots[idx_d];
    an_d  = 8'hFF;
    if (state_d == ST_SHOW && shadow_d.en[idx_d] && !supp[idx_d])
      an_d = ~(8'd1 << idx_d);
  end

  assign bus.upd_pending = upd_q;
  assign bus.frame_tick  = tick_q;
  assign bus.hex         = hex_q;
  assign bus.dot         = dot_q;
  assign bus.an          = an_q;

endmodule

// File: tb/tb_nexys4_7seg_scan.sv
// Purpose : self-checking bench for nexys4_7seg_scan with DIGIT_CYCLES=4, BLANK_CYCLES=2 (48-cycle frame).
// Latency : n/a.
// Backpr. : n/a.
module tb_nexys4_7seg_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nexys4_7seg_scan_if bus();

  nexys4_7seg_scan #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: edges since reset release, and the two display buffers.
  int          k = 0;
  logic [31:0] s_val = '0, p_val = '0;
  logic [7:0]  s_dots = '0, p_dots = '0, s_en = '0, p_en = '0;
  logic        m_upd = 1'b0, m_tick = 1'b0;
  int          h[8];
  int          h_dark;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  function automatic logic m_supp(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < 8; j++)
      if (((s_val >> (4 * j)) & 32'hF) != 0 || s_dots[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Frame position from edge count: 8 digits of (2 blank + 4 lit) cycles.
  always @(posedge clk) begin
    logic ld, xfer;
    logic [31:0] v;
    logic [7:0] dd, ee, ean;
    int pos, d;
    if (!rst_n) begin
      k = 0; s_val = '0; p_val = '0; s_dots = '0; p_dots = '0;
      s_en = '0; p_en = '0; m_upd = 1'b0; m_tick = 1'b0;
    end else begin
      ld = bus.load; v = bus.value; dd = bus.dots; ee = bus.digit_en;
      k++;
      xfer = ((k % 48) == 0) && m_upd;
      m_tick = xfer;
      if (xfer) begin s_val = p_val; s_dots = p_dots; s_en = p_en; end
      if (ld) begin p_val = v; p_dots = dd; p_en = ee; m_upd = 1'b1; end
      else if (xfer) m_upd = 1'b0;
      #1;
      if (rst_n) begin
        pos = k % 48;
        d   = pos / 6;
        ean = ((pos % 6) >= 2 && s_en[d] && !m_supp(d)) ? ~(8'd1 << d) : 8'hFF;
        chk("an", {24'd0, bus.an}, {24'd0, ean});
        chk("hex", {28'd0, bus.hex}, (s_val >> (4 * d)) & 32'hF);
        chk("dot", {31'd0, bus.dot}, {31'd0, ~s_dots[d]});
        chk("frame_tick", {31'd0, bus.frame_tick}, {31'd0, m_tick});
        chk("upd_pending", {31'd0, bus.upd_pending}, {31'd0, m_upd});
      end
    end
  end

  task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e);
    @(negedge clk);
    bus.load = 1'b1; bus.value = v; bus.dots = d; bus.digit_en = e;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while ((k % 48) != target && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total++; bad++; $display("FAIL wait_pos %0d: timed out, want reached", target); end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.frame_tick && n < 100);
    if (n >= 100) begin total++; bad++; $display("FAIL wait_tick: frame_tick 0 after 100 cycles, want 1"); end
  endtask

  // Histogram of anode patterns over one frame, sampled mid-cycle.
  task automatic hist48();
    for (int i = 0; i < 8; i++) h[i] = 0;
    h_dark = 0;
    for (int c = 0; c < 48; c++) begin
      if (bus.an == 8'hFF) h_dark++;
      for (int i = 0; i < 8; i++) if (bus.an == ~(8'd1 << i)) h[i]++;
      @(negedge clk);
    end
  endtask

  initial begin
    int ticks;
    logic [31:0] v;
    bus.load = 1'b0; bus.value = '0; bus.dots = '0; bus.digit_en = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst an", {24'd0, bus.an}, 32'hFF);
    chk("rst hex", {28'd0, bus.hex}, 32'h0);
    chk("rst dot", {31'd0, bus.dot}, 32'h1);
    chk("rst upd", {31'd0, bus.upd_pending}, 32'h0);
    repeat (96) @(negedge clk);

    // Basic load and display.
    wait_pos(10);
    do_load(32'h1234_ABCD, 8'h01, 8'hFF);
    chk("upd after load", {31'd0, bus.upd_pending}, 32'h1);
    wait_tick();
    chk("d0 blank an", {24'd0, bus.an}, 32'hFF);
    chk("d0 blank hex", {28'd0, bus.hex}, 32'hD);
    repeat (2) @(negedge clk);
    chk("d0 an", {24'd0, bus.an}, 32'hFE);
    chk("d0 hex", {28'd0, bus.hex}, 32'hD);
    chk("d0 dot", {31'd0, bus.dot}, 32'h0);
    wait_pos(44);
    chk("d7 an", {24'd0, bus.an}, 32'h7F);
    chk("d7 hex", {28'd0, bus.hex}, 32'h1);
    chk("d7 dot", {31'd0, bus.dot}, 32'h1);
    wait_pos(0);
    ticks = 0;
    for (int c = 0; c < 48; c++) begin ticks += int'(bus.frame_tick); @(negedge clk); end
    chk("no tick idle frame", ticks, 0);

    // Per-digit enable.
    do_load(32'h8765_4321, 8'h00, 8'b1010_1010);
    wait_tick();
    hist48();
    chk("en FE", h[0], 0); chk("en FD", h[1], 4); chk("en FB", h[2], 0); chk("en F7", h[3], 4);
    chk("en EF", h[4], 0); chk("en DF", h[5], 4); chk("en BF", h[6], 0); chk("en 7F", h[7], 4);

    // Load coinciding with the frame boundary.
    wait_pos(10);
    do_load(32'hA5A5_A5A5, 8'h00, 8'hFF);
    wait_pos(47);
    bus.load = 1'b1; bus.value = 32'h3C3C_3C3C; bus.dots = 8'h00; bus.digit_en = 8'hFF;
    @(negedge clk);
    bus.load = 1'b0;
    chk("coinc tick", {31'd0, bus.frame_tick}, 32'h1);
    chk("coinc upd", {31'd0, bus.upd_pending}, 32'h1);
    chk("coinc hex A", {28'd0, bus.hex}, 32'h5);
    wait_tick();
    chk("second upd", {31'd0, bus.upd_pending}, 32'h0);
    chk("second hex B", {28'd0, bus.hex}, 32'hC);

    // Asynchronous reset in the middle of digit 3.
    wait_pos(21);
    chk("pre-rst an", {24'd0, bus.an}, 32'hF7);
    rst_n = 1'b0;
    #1;
    chk("arst an", {24'd0, bus.an}, 32'hFF);
    chk("arst hex", {28'd0, bus.hex}, 32'h0);
    chk("arst dot", {31'd0, bus.dot}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist48();
    chk("dark after rst", h_dark, 48);
    repeat (48) @(negedge clk);

    // Random loads at random times against the model.
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 70)) @(negedge clk);
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, 8));
      do_load(v, ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00, 8'($urandom));
    end
    repeat (100) @(negedge clk);

`ifdef LEADING_ZERO_BLANK_EN
    do_load(32'h0000_00A0, 8'h00, 8'hFF);
    wait_tick();
    hist48();
    chk("lzb A0 AN0", h[0], 4); chk("lzb A0 AN1", h[1], 4); chk("lzb A0 AN2", h[2], 0);
    do_load(32'h0, 8'h00, 8'hFF);
    wait_tick();
    hist48();
    chk("lzb 0 AN0", h[0], 4); chk("lzb 0 AN1", h[1], 0);
    do_load(32'h0, 8'h10, 8'hFF);
    wait_tick();
    hist48();
    chk("lzb dot AN4", h[4], 4); chk("lzb dot AN3", h[3], 4); chk("lzb dot AN5", h[5], 0);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
